// File: rtl/microwatt_ctrl_pkg.sv
// Shared definitions for the microwatt boot controller: FSM state encoding,
// Wishbone register offsets and CTRL bit positions.
package microwatt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HOLD = 2'd1,
        ST_REL  = 2'd2,
        ST_RUN  = 2'd3
    } boot_state_t;

    // Register index is wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_HOLD    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int CTRL_RUN_EN_BIT   = 0;
    localparam int CTRL_SOFT_RST_BIT = 1;

endpackage

// File: rtl/mwb_regs.sv
// Wishbone slave and register file for the boot controller. Exports the
// run enable, a one-cycle soft reset pulse and the reset-hold value.
module mwb_regs
    import microwatt_ctrl_pkg::*;
#(
    parameter int                HOLD_W       = 16,
    parameter logic [HOLD_W-1:0] HOLD_DEFAULT = 16'd64,
    parameter bit                AUTO_BOOT    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [1:0]        status_state,
    input  logic [7:0]        status_boot_cnt,
    output logic              run_en,
    output logic              soft_rst,
    output logic [HOLD_W-1:0] hold_val
);

    logic              ack_reg;
    logic [31:0]       dat_reg;
    logic              run_en_reg;
    logic              soft_rst_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic [31:0]       scratch_reg;

    logic              req;
    logic              wr;
    logic [31:0]       lane_mask;
    logic [31:0]       rd_data;
    logic [31:0]       scratch_next;
    logic [HOLD_W-1:0] hold_next;
    logic              unused_adr_bits;

    // A request is only taken while no ack is outstanding, giving 1 ack per 2 cycles
    assign req = wbs_stb_i & wbs_cyc_i & ~ack_reg;
    assign wr  = req & wbs_we_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end

    assign scratch_next = (scratch_reg & ~lane_mask) | (wbs_dat_i & lane_mask);
    assign hold_next    = (hold_reg & ~lane_mask[HOLD_W-1:0])
                        | (wbs_dat_i[HOLD_W-1:0] & lane_mask[HOLD_W-1:0]);

    assign unused_adr_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    always_comb begin
        rd_data = '0;
        case (wbs_adr_i[3:2])
            REG_CTRL:   rd_data[CTRL_RUN_EN_BIT] = run_en_reg;
            REG_HOLD:   rd_data[HOLD_W-1:0] = hold_reg;
            REG_STATUS: begin
                rd_data[1:0]  = status_state;
                rd_data[15:8] = status_boot_cnt;
            end
            default:    rd_data = scratch_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            run_en_reg   <= AUTO_BOOT;
            soft_rst_reg <= 1'b0;
            hold_reg     <= HOLD_DEFAULT;
            scratch_reg  <= '0;
        end else begin
            ack_reg      <= req;
            dat_reg      <= (req && !wbs_we_i) ? rd_data : '0;
            soft_rst_reg <= 1'b0;
            if (wr) begin
                case (wbs_adr_i[3:2])
                    REG_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            run_en_reg   <= wbs_dat_i[CTRL_RUN_EN_BIT];
                            soft_rst_reg <= wbs_dat_i[CTRL_SOFT_RST_BIT];
                        end
                    end
                    REG_HOLD:    hold_reg    <= hold_next;
                    REG_SCRATCH: scratch_reg <= scratch_next;
                    default:     ;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign run_en    = run_en_reg;
    assign soft_rst  = soft_rst_reg;
    assign hold_val  = hold_reg;

endmodule

// File: rtl/microwatt_boot_ctrl.sv
// Boot sequencer for the microwatt core: holds the core in reset for a
// programmable time, releases it, then enables the core output pads.
module microwatt_boot_ctrl
    import microwatt_ctrl_pkg::*;
#(
    parameter int                HOLD_W       = 16,
    parameter logic [HOLD_W-1:0] HOLD_DEFAULT = 16'd64,
    parameter int                IO_DELAY     = 4,
    parameter bit                AUTO_BOOT    = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        ext_rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_halt,
    output logic        core_rst_n,
    output logic        io_out_en,
    output logic [1:0]  boot_state
);

    localparam int DLY_W = (IO_DELAY > 1) ? $clog2(IO_DELAY) : 1;

    boot_state_t       state_reg;
    logic [HOLD_W-1:0] cnt_reg;
    logic [DLY_W-1:0]  dly_reg;
    logic [7:0]        boot_cnt_reg;
    logic              core_rst_n_reg;
    logic              io_out_en_reg;

    logic              run_en;
    logic              soft_rst;
    logic [HOLD_W-1:0] hold_val;

    mwb_regs #(
        .HOLD_W       (HOLD_W),
        .HOLD_DEFAULT (HOLD_DEFAULT),
        .AUTO_BOOT    (AUTO_BOOT)
    ) u_regs (
        .clk             (wb_clk_i),
        .rst_n           (ext_rst),
        .wbs_stb_i       (wbs_stb_i),
        .wbs_cyc_i       (wbs_cyc_i),
        .wbs_we_i        (wbs_we_i),
        .wbs_sel_i       (wbs_sel_i),
        .wbs_adr_i       (wbs_adr_i),
        .wbs_dat_i       (wbs_dat_i),
        .wbs_ack_o       (wbs_ack_o),
        .wbs_dat_o       (wbs_dat_o),
        .status_state    (state_reg),
        .status_boot_cnt (boot_cnt_reg),
        .run_en          (run_en),
        .soft_rst        (soft_rst),
        .hold_val        (hold_val)
    );

    // Outputs are updated together with the state so they never glitch
    always_ff @(posedge wb_clk_i or negedge ext_rst) begin
        if (!ext_rst) begin
            state_reg      <= ST_OFF;
            cnt_reg        <= '0;
            dly_reg        <= '0;
            boot_cnt_reg   <= '0;
            core_rst_n_reg <= 1'b0;
            io_out_en_reg  <= 1'b0;
        end else if (state_reg != ST_OFF && (!run_en || la_halt)) begin
            state_reg      <= ST_OFF;
            core_rst_n_reg <= 1'b0;
            io_out_en_reg  <= 1'b0;
        end else if (state_reg != ST_OFF && soft_rst) begin
            state_reg      <= ST_HOLD;
            cnt_reg        <= hold_val;
            core_rst_n_reg <= 1'b0;
            io_out_en_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    if (run_en && !la_halt) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= hold_val;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg      <= ST_REL;
                        dly_reg        <= DLY_W'(IO_DELAY - 1);
                        core_rst_n_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - HOLD_W'(1);
                    end
                end
                ST_REL: begin
                    if (dly_reg == '0) begin
                        state_reg     <= ST_RUN;
                        io_out_en_reg <= 1'b1;
                        if (boot_cnt_reg != 8'hFF) begin
                            boot_cnt_reg <= boot_cnt_reg + 8'd1;
                        end
                    end else begin
                        dly_reg <= dly_reg - DLY_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_rst_n = core_rst_n_reg;
    assign io_out_en  = io_out_en_reg;
    assign boot_state = state_reg;

endmodule

// File: tb/tb_microwatt_boot_ctrl.sv
// Randomised bench for microwatt_boot_ctrl with a timeline-based reference
// model: the expected state is derived from cycles elapsed since HOLD entry.
module tb_microwatt_boot_ctrl;

    localparam int          IO_DELAY     = 4;
    localparam logic [15:0] HOLD_DEFAULT = 16'd64;

    logic        wb_clk_i = 1'b0;
    logic        ext_rst  = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_halt = 1'b0;
    logic        core_rst_n;
    logic        io_out_en;
    logic [1:0]  boot_state;

    always #5 wb_clk_i = ~wb_clk_i;

    microwatt_boot_ctrl #(
        .HOLD_W       (16),
        .HOLD_DEFAULT (HOLD_DEFAULT),
        .IO_DELAY     (IO_DELAY),
        .AUTO_BOOT    (1'b0)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .ext_rst    (ext_rst),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .la_halt    (la_halt),
        .core_rst_n (core_rst_n),
        .io_out_en  (io_out_en),
        .boot_state (boot_state)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: a boot is a timeline starting at m_start; OFF is a flag
    int unsigned cyc_idx;
    int unsigned m_start;
    int unsigned m_len;
    bit          m_off;
    bit          m_run_en;
    bit          m_soft;
    logic [15:0] m_hold;
    logic [31:0] m_scratch;
    int          m_boot;
    bit          m_ack;
    logic [31:0] m_dat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_idx);
        end
    endtask

    function automatic int exp_state(input int unsigned c);
        int unsigned e;
        if (m_off) return 0;
        e = c - m_start;
        if (e <= m_len) return 1;
        if (e <= m_len + IO_DELAY) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        cyc_idx   = 0;
        m_start   = 0;
        m_len     = 0;
        m_off     = 1'b1;
        m_run_en  = 1'b0;
        m_soft    = 1'b0;
        m_hold    = HOLD_DEFAULT;
        m_scratch = '0;
        m_boot    = 0;
        m_ack     = 1'b0;
        m_dat     = '0;
    endtask

    // Advance the model across one rising edge using the inputs of the ending cycle
    task automatic model_step();
        int          s_now;
        int          s_nxt;
        logic [1:0]  s2;
        logic [7:0]  b8;
        logic [31:0] rd;
        bit          acc;
        s_now = exp_state(cyc_idx);
        s2    = 2'(s_now);
        b8    = 8'(m_boot);
        acc   = wbs_stb_i && wbs_cyc_i && !m_ack;
        case (wbs_adr_i[3:2])
            2'd0:    rd = {31'd0, m_run_en};
            2'd1:    rd = {16'd0, m_hold};
            2'd2:    rd = {16'd0, b8, 6'd0, s2};
            default: rd = m_scratch;
        endcase
        if (s_now != 0 && (!m_run_en || la_halt)) begin
            m_off = 1'b1;
        end else if (s_now != 0 && m_soft) begin
            m_start = cyc_idx + 1;
            m_len   = m_hold;
        end else if (s_now == 0 && m_run_en && !la_halt) begin
            m_off   = 1'b0;
            m_start = cyc_idx + 1;
            m_len   = m_hold;
        end
        s_nxt = exp_state(cyc_idx + 1);
        if (s_nxt == 3 && s_now != 3 && m_boot < 255) m_boot++;
        m_soft = 1'b0;
        m_ack  = acc;
        m_dat  = (acc && !wbs_we_i) ? rd : '0;
        if (acc && wbs_we_i) begin
            case (wbs_adr_i[3:2])
                2'd0: if (wbs_sel_i[0]) begin
                    m_run_en = wbs_dat_i[0];
                    m_soft   = wbs_dat_i[1];
                end
                2'd1: for (int b = 0; b < 2; b++)
                    if (wbs_sel_i[b]) m_hold[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
                2'd3: for (int b = 0; b < 4; b++)
                    if (wbs_sel_i[b]) m_scratch[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
                default: ;
            endcase
        end
        cyc_idx++;
    endtask

    task automatic tick();
        int s;
        @(posedge wb_clk_i);
        if (ext_rst) model_step();
        @(negedge wb_clk_i);
        s = exp_state(cyc_idx);
        check_val("boot_state", 32'(boot_state), 32'(s));
        check_val("core_rst_n", 32'(core_rst_n), (s >= 2) ? 32'd1 : 32'd0);
        check_val("io_out_en", 32'(io_out_en), (s == 3) ? 32'd1 : 32'd0);
        check_val("wbs_ack_o", 32'(wbs_ack_o), 32'(m_ack));
        check_val("wbs_dat_o", wbs_dat_o, m_dat);
    endtask

    task automatic wb_xfer(input bit we, input logic [1:0] idx, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
        logic [31:0] r;
        r = $urandom();
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = {r[31:4], idx, 2'b00};
        wbs_dat_i = dat;
        tick();
        rdata = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        tick();
    endtask

    task automatic wb_write(input logic [1:0] idx, input logic [31:0] dat);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, idx, dat, 4'hF, unused_rd);
    endtask

    task automatic wb_read(input logic [1:0] idx, output logic [31:0] rdata);
        wb_xfer(1'b0, idx, 32'h0, 4'hF, rdata);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rnd;
        int          n;
        int          op;

        model_reset();
        repeat (3) tick();
        ext_rst = 1'b1;

        // Idle with AUTO_BOOT=0: core stays in reset
        repeat (100) tick();
        wb_read(2'd2, rd);  check_val("t1_status", rd, 32'h0);
        wb_read(2'd1, rd);  check_val("t1_hold_default", rd, 32'd64);
        wb_read(2'd0, rd);  check_val("t1_ctrl", rd, 32'h0);

        // HOLD=10: release after 11 HOLD cycles, pads IO_DELAY later
        wb_write(2'd1, 32'd10);
        wb_write(2'd0, 32'd1);
        check_val("t2_in_hold", 32'(boot_state), 32'd1);
        n = 0;
        while (core_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        check_val("t2_hold_cycles", 32'(n), 32'd11);
        n = 0;
        while (io_out_en !== 1'b1 && n < 200) begin tick(); n++; end
        check_val("t2_io_delay", 32'(n), 32'd4);
        wb_read(2'd2, rd);  check_val("t2_status", rd, 32'h0103);

        // Soft reset from RUN re-sequences
        wb_write(2'd0, 32'd3);
        check_val("t3_rst_low", 32'(core_rst_n), 32'd0);
        repeat (20) tick();
        wb_read(2'd2, rd);  check_val("t3_status", rd, 32'h0203);

        // la_halt during REL forces OFF; release re-boots
        wb_write(2'd0, 32'd3);
        repeat (11) tick();
        check_val("t4_in_rel", 32'(boot_state), 32'd2);
        la_halt = 1'b1;
        tick();
        check_val("t4_halt_off", 32'(boot_state), 32'd0);
        repeat (5) tick();
        check_val("t4_halt_rst", 32'(core_rst_n), 32'd0);
        la_halt = 1'b0;
        tick();
        check_val("t4_reboot", 32'(boot_state), 32'd1);
        repeat (20) tick();
        wb_read(2'd2, rd);  check_val("t4_status", rd, 32'h0303);

        // run_en=0 together with soft_rst: OFF wins
        wb_write(2'd0, 32'd2);
        check_val("t4b_off_wins", 32'(boot_state), 32'd0);
        wb_write(2'd0, 32'd1);
        repeat (20) tick();
        wb_read(2'd2, rd);  check_val("t4b_status", rd, 32'h0403);

        // HOLD=0 gives a single HOLD cycle; boot_cnt saturates
        wb_write(2'd1, 32'd0);
        wb_write(2'd0, 32'd3);
        check_val("t5_hold0_a", 32'(boot_state), 32'd1);
        tick();
        check_val("t5_hold0_b", 32'(boot_state), 32'd2);
        for (int i = 0; i < 260; i++) begin
            wb_write(2'd0, 32'd3);
            repeat (8) tick();
        end
        wb_read(2'd2, rd);  check_val("t5_saturate", rd, 32'hFF03);

        // Randomised traffic against the model
        for (int i = 0; i < 250; i++) begin
            op  = $urandom_range(0, 6);
            rnd = $urandom();
            case (op)
                0: wb_xfer(1'b1, 2'd0, {30'd0, rnd[1], (rnd[3:2] != 2'd0)}, rnd[7:4], rd);
                1: wb_xfer(1'b1, 2'd1, {rnd[31:16], 11'd0, rnd[4:0]} & 32'hFFFF_001F, rnd[11:8] | 4'h1, rd);
                2: wb_xfer(1'b1, 2'd3, $urandom(), rnd[3:0], rd);
                3: wb_xfer(1'b0, rnd[1:0], $urandom(), rnd[7:4], rd);
                4: begin la_halt = (rnd[1:0] == 2'd0); tick(); end
                5: repeat ($urandom_range(1, 12)) tick();
                default: begin
                    wbs_stb_i = 1'b1;
                    wbs_cyc_i = 1'b1;
                    wbs_we_i  = 1'b0;
                    wbs_adr_i = {28'd0, rnd[1:0], 2'b00};
                    repeat (4) tick();
                    wbs_stb_i = 1'b0;
                    wbs_cyc_i = 1'b0;
                    tick();
                end
            endcase
        end
        la_halt = 1'b0;

        // Async reset mid-HOLD with a write in flight
        wb_write(2'd1, 32'd30);
        wb_write(2'd0, 32'd3);
        repeat (3) tick();
        check_val("t6_in_hold", 32'(boot_state), 32'd1);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h4;
        wbs_dat_i = 32'd5;
        #2;
        ext_rst = 1'b0;
        model_reset();
        #1;
        check_val("t6_rst_core", 32'(core_rst_n), 32'd0);
        check_val("t6_rst_io", 32'(io_out_en), 32'd0);
        check_val("t6_rst_state", 32'(boot_state), 32'd0);
        check_val("t6_rst_ack", 32'(wbs_ack_o), 32'd0);
        check_val("t6_rst_dat", wbs_dat_o, 32'd0);
        repeat (3) tick();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        ext_rst   = 1'b1;
        tick();
        wb_read(2'd1, rd);  check_val("t6_hold_default", rd, 32'd64);
        wb_read(2'd0, rd);  check_val("t6_ctrl_default", rd, 32'h0);
        wb_read(2'd3, rd);  check_val("t6_scratch_default", rd, 32'h0);
        wb_read(2'd2, rd);  check_val("t6_status_default", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
